// File: rtl/mesi_snoop_ctrl_if.sv
// ----------------------------------------------------------------------------
// mesi_snoop_ctrl_if
// Snoop-bus bundle between the shared snoop bus and the MESI snoop controller.
//
// Signals:
//   snoop_valid / snoop_ready   snoop request handshake
//   snoop_op                    01 readMiss, 10 writeMiss, 11 invalidate, 00 ignored
//   snoop_addr                  snooped address {tag, index}
//   abort_mem                   tells memory to abort while a Modified line is written back
//   wb_valid / wb_ready         write-back handshake
//   wb_addr / wb_data           write-back address and line data
//   snoop_done / snoop_hit      one-cycle completion pulse and hit flag
//
// Modports:
//   master  bus side (drives the request and wb_ready)
//   slave   controller side
// ----------------------------------------------------------------------------
interface mesi_snoop_ctrl_if #(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32
);
    localparam int ADDR_W = TAG_W + INDEX_W;

    logic              snoop_valid;
    logic              snoop_ready;
    logic [1:0]        snoop_op;
    logic [ADDR_W-1:0] snoop_addr;
    logic              abort_mem;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              snoop_done;
    logic              snoop_hit;

    modport master (
        output snoop_valid, snoop_op, snoop_addr, wb_ready,
        input  snoop_ready, abort_mem, wb_valid, wb_addr, wb_data,
               snoop_done, snoop_hit
    );

    modport slave (
        input  snoop_valid, snoop_op, snoop_addr, wb_ready,
        output snoop_ready, abort_mem, wb_valid, wb_addr, wb_data,
               snoop_done, snoop_hit
    );
endinterface

// File: rtl/mesi_snoop_ctrl.sv
// ----------------------------------------------------------------------------
// mesi_snoop_ctrl
// Bus-side MESI snoop controller for a direct-mapped cache of 2**INDEX_W lines.
// Keeps a tag, MESI state and line data per line, accepts one snoop at a time,
// applies the bus-side MESI transition to the addressed line, and writes a
// Modified line back (with a memory abort) before giving it up on a read/write miss.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-low reset
//   bus        snoop-bus bundle (mesi_snoop_ctrl_if.slave)
//   cpu_we     install/update a line, honoured only while cpu_ready
//   cpu_ready  same as snoop_ready (high only when idle)
//   cpu_index / cpu_tag / cpu_state / cpu_data   line contents to install
//   proto_err  sticky: invalidate seen on a Modified line, cleared only by reset
//   hit_count  snoop hit counter   (live only with SNOOP_STATS_EN)
//   wb_count   write-back counter  (live only with SNOOP_STATS_EN)
//
// State encoding: 000 I, 001 M, 010 S, 011 E; codes 1xx are stored as I.
//
// Build option: define SNOOP_STATS_EN to enable the saturating 16-bit
// hit/write-back counters; without it both outputs are tied to zero.
// ----------------------------------------------------------------------------
module mesi_snoop_ctrl #(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32
) (
    input  logic               clock,
    input  logic               reset,
    mesi_snoop_ctrl_if.slave   bus,
    input  logic               cpu_we,
    output logic               cpu_ready,
    input  logic [INDEX_W-1:0] cpu_index,
    input  logic [TAG_W-1:0]   cpu_tag,
    input  logic [2:0]         cpu_state,
    input  logic [DATA_W-1:0]  cpu_data,
    output logic               proto_err,
    output logic [15:0]        hit_count,
    output logic [15:0]        wb_count
);
    localparam int ADDR_W    = TAG_W + INDEX_W;
    localparam int NUM_LINES = 1 << INDEX_W;

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_M = 2'b01;
    localparam logic [1:0] ST_S = 2'b10;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_INV  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WB     = 2'd2,
        RESP   = 2'd3
    } fsm_t;

    // Codes with the top bit set carry no valid MESI meaning and are kept as I.
    function automatic logic [1:0] decodeState(input logic [2:0] code);
        return code[2] ? ST_I : code[1:0];
    endfunction

    // Every bus-side hit ends in S for a readMiss and in I otherwise,
    // whatever the starting state (M, S or E).
    function automatic logic [1:0] snoopNext(input logic [1:0] op);
        return (op == OP_RD) ? ST_S : ST_I;
    endfunction

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    fsm_t state;
    fsm_t nextState;

    logic [1:0]        snoopOp_p0;
    logic [ADDR_W-1:0] snoopAddr_p0;
    logic              snoopHit_p1;
    logic              protoErr;

    logic [TAG_W-1:0]  tagArr   [NUM_LINES];
    logic [1:0]        stateArr [NUM_LINES];
    logic [DATA_W-1:0] dataArr  [NUM_LINES];

    logic [INDEX_W-1:0] lineIdx;
    logic [TAG_W-1:0]   lineTag;
    logic [1:0]         lineState;
    logic               lineHit;
    logic               needWb;

    logic snoopReady;
    logic accept;
    logic abortMem;
    logic wbValid;
    logic doneRaw;
    logic lineWe;
    logic cpuWrite;

    assign lineIdx   = snoopAddr_p0[INDEX_W-1:0];
    assign lineTag   = snoopAddr_p0[ADDR_W-1:INDEX_W];
    assign lineState = stateArr[lineIdx];
    assign lineHit   = (tagArr[lineIdx] == lineTag) && (lineState != ST_I);
    // Only a Modified line leaving on a miss owes memory its data.
    assign needWb    = lineHit && (lineState == ST_M) && (snoopOp_p0 != OP_INV);
    assign cpuWrite  = cpu_we && snoopReady;

    always_comb begin
        nextState  = state;
        snoopReady = 1'b0;
        accept     = 1'b0;
        abortMem   = 1'b0;
        wbValid    = 1'b0;
        doneRaw    = 1'b0;
        lineWe     = 1'b0;
        case (state)
            IDLE: begin
                snoopReady = 1'b1;
                if (bus.snoop_valid && (bus.snoop_op != OP_NONE)) begin
                    accept    = 1'b1;
                    nextState = LOOKUP;
                end
            end
            LOOKUP: begin
                if (needWb) begin
                    abortMem  = 1'b1;
                    nextState = WB;
                end else begin
                    lineWe    = lineHit;
                    nextState = RESP;
                end
            end
            WB: begin
                abortMem = 1'b1;
                wbValid  = 1'b1;
                if (bus.wb_ready) begin
                    lineWe    = 1'b1;
                    nextState = RESP;
                end
            end
            RESP: begin
                doneRaw   = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Stage p0: request captured at accept; p1: hit result captured in LOOKUP.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snoopOp_p0   <= OP_NONE;
            snoopAddr_p0 <= '0;
            snoopHit_p1  <= 1'b0;
            protoErr     <= 1'b0;
        end else begin
            if (accept) begin
                snoopOp_p0   <= bus.snoop_op;
                snoopAddr_p0 <= bus.snoop_addr;
            end
            if (state == LOOKUP) begin
                snoopHit_p1 <= lineHit;
                if (lineHit && (lineState == ST_M) && (snoopOp_p0 == OP_INV)) begin
                    protoErr <= 1'b1;
                end
            end
        end
    end

    // CPU writes only happen in IDLE and snoop updates only in LOOKUP/WB, so the
    // two never collide; an IDLE write is visible to the LOOKUP that follows.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                tagArr[i]   <= '0;
                stateArr[i] <= ST_I;
                dataArr[i]  <= '0;
            end
        end else if (cpuWrite) begin
            tagArr[cpu_index]   <= cpu_tag;
            stateArr[cpu_index] <= decodeState(cpu_state);
            dataArr[cpu_index]  <= cpu_data;
        end else if (lineWe) begin
            stateArr[lineIdx] <= snoopNext(snoopOp_p0);
        end
    end

`ifdef SNOOP_STATS_EN
    logic [15:0] hitCnt;
    logic [15:0] wbCnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hitCnt <= '0;
            wbCnt  <= '0;
        end else begin
            if (doneRaw && snoopHit_p1) begin
                hitCnt <= satInc(hitCnt);
            end
            if (wbValid && bus.wb_ready) begin
                wbCnt <= satInc(wbCnt);
            end
        end
    end

    assign hit_count = hitCnt;
    assign wb_count  = wbCnt;
`else
    assign hit_count = 16'd0;
    assign wb_count  = 16'd0;
`endif

    // Handshake outputs are decoded from the state register, so an asynchronous
    // reset drops wb_valid/abort_mem at once and cancels any pending snoop_done.
    assign bus.snoop_ready = snoopReady;
    assign cpu_ready       = snoopReady;
    assign bus.abort_mem   = abortMem;
    assign bus.wb_valid    = wbValid;
    assign bus.wb_addr     = wbValid ? snoopAddr_p0 : '0;
    assign bus.wb_data     = wbValid ? dataArr[lineIdx] : '0;
    assign bus.snoop_done  = doneRaw;
    assign bus.snoop_hit   = doneRaw && snoopHit_p1;
    assign proto_err       = protoErr;
endmodule

// File: tb/tb_mesi_snoop_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mesi_snoop_ctrl
// Self-checking bench for mesi_snoop_ctrl: a table of directed vectors, a few
// hand-written multi-cycle sequences (ignored op, same-cycle install+snoop,
// install while busy, reset during write-back) and a randomized run checked
// against a line-level MESI model kept in letters (I/M/S/E).
// ----------------------------------------------------------------------------
module tb_mesi_snoop_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_we = 1'b0;
    logic        cpu_ready;
    logic [2:0]  cpu_index = '0;
    logic [4:0]  cpu_tag = '0;
    logic [2:0]  cpu_state = '0;
    logic [31:0] cpu_data = '0;
    logic        proto_err;
    logic [15:0] hit_count;
    logic [15:0] wb_count;

    always #5 clock = ~clock;

    mesi_snoop_ctrl_if #(.INDEX_W(3), .TAG_W(5), .DATA_W(32)) busIf ();

    mesi_snoop_ctrl #(.INDEX_W(3), .TAG_W(5), .DATA_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (busIf),
        .cpu_we    (cpu_we),
        .cpu_ready (cpu_ready),
        .cpu_index (cpu_index),
        .cpu_tag   (cpu_tag),
        .cpu_state (cpu_state),
        .cpu_data  (cpu_data),
        .proto_err (proto_err),
        .hit_count (hit_count),
        .wb_count  (wb_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one record per line, state held as a MESI letter.
    byte         mState [8];
    logic [4:0]  mTag   [8];
    logic [31:0] mData  [8];
    bit          mProto;
    int          mHits;
    int          mWbs;

    typedef struct {
        bit          we;
        logic [2:0]  idx;
        logic [4:0]  tag;
        logic [2:0]  st;
        logic [31:0] data;
        logic [1:0]  op;
        logic [7:0]  addr;
        int          waitN;
        bit          expHit;
        int          expWb;
        bit          expProto;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic byte letterOf(input logic [2:0] code);
        case (code)
            3'b001:  return "M";
            3'b010:  return "S";
            3'b011:  return "E";
            default: return "I";
        endcase
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            mState[i] = "I";
            mTag[i]   = '0;
            mData[i]  = '0;
        end
        mProto = 0;
        mHits  = 0;
        mWbs   = 0;
    endtask

    task automatic modelWrite(input logic [2:0] idx, input logic [4:0] tag,
                              input logic [2:0] st, input logic [31:0] data);
        mState[idx] = letterOf(st);
        mTag[idx]   = tag;
        mData[idx]  = data;
    endtask

    // Bus-side MESI rules: a hit leaves S on readMiss and I otherwise;
    // a Modified line writes back on a miss, or flags an error on invalidate.
    task automatic modelSnoop(input logic [1:0] op, input logic [7:0] addr,
                              output bit hit, output bit wb, output logic [31:0] wbData);
        int idx;
        idx    = int'(addr[2:0]);
        hit    = (mTag[idx] == addr[7:3]) && (mState[idx] != "I");
        wb     = 0;
        wbData = mData[idx];
        if (hit) begin
            if (mState[idx] == "M") begin
                if (op == 2'b11) mProto = 1;
                else begin
                    wb = 1;
                    if (mWbs < 65535) mWbs++;
                end
            end
            mState[idx] = (op == 2'b01) ? "S" : "I";
            if (mHits < 65535) mHits++;
        end
    endtask

    task automatic checkStatus(input string tag);
        check({tag, "_proto"}, proto_err, mProto);
`ifdef SNOOP_STATS_EN
        check({tag, "_hitcnt"}, hit_count, mHits);
        check({tag, "_wbcnt"}, wb_count, mWbs);
`else
        check({tag, "_hitcnt"}, hit_count, 0);
        check({tag, "_wbcnt"}, wb_count, 0);
`endif
    endtask

    task automatic cpuWrite(input logic [2:0] idx, input logic [4:0] tag,
                            input logic [2:0] st, input logic [31:0] data);
        @(negedge clock);
        cpu_we = 1; cpu_index = idx; cpu_tag = tag; cpu_state = st; cpu_data = data;
        @(posedge clock);
        #1 cpu_we = 0;
        modelWrite(idx, tag, st, data);
    endtask

    // One snoop from accept to snoop_done. simWe installs a line in the accept
    // cycle; busyWe attempts an install to the snooped line while busy.
    task automatic snoopTxn(input string name, input logic [1:0] op, input logic [7:0] addr,
                            input int waitN, input bit simWe, input logic [2:0] sIdx,
                            input logic [4:0] sTag, input logic [2:0] sSt,
                            input logic [31:0] sData, input bit busyWe,
                            output bit gotHit, output int wbCyc);
        bit          expHit, expWb, dataOk;
        logic [31:0] expData;
        int          cyc, doneCyc, abCyc, expDone;
        @(negedge clock);
        check({name, "_idleReady"}, busIf.snoop_ready, 1);
        check({name, "_cpuReady"}, cpu_ready, 1);
        check({name, "_donePulse"}, busIf.snoop_done, 0);
        busIf.snoop_valid = 1; busIf.snoop_op = op; busIf.snoop_addr = addr;
        if (simWe) begin
            cpu_we = 1; cpu_index = sIdx; cpu_tag = sTag; cpu_state = sSt; cpu_data = sData;
        end
        @(posedge clock);
        #1;
        busIf.snoop_valid = 0;
        cpu_we = 0;
        if (simWe) modelWrite(sIdx, sTag, sSt, sData);
        modelSnoop(op, addr, expHit, expWb, expData);
        cyc = 0; doneCyc = -1; abCyc = 0; wbCyc = 0; dataOk = 1; gotHit = 0;
        while (cyc < 60 && doneCyc < 0) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) begin
                check({name, "_busyReady"}, busIf.snoop_ready, 0);
                if (busyWe) begin
                    cpu_we = 1; cpu_index = addr[2:0]; cpu_tag = addr[7:3];
                    cpu_state = 3'b001; cpu_data = 32'h0BAD0BAD;
                end
            end else begin
                cpu_we = 0;
            end
            if (busIf.abort_mem) abCyc++;
            if (busIf.wb_valid) begin
                wbCyc++;
                if (busIf.wb_data !== expData || busIf.wb_addr !== addr) dataOk = 0;
                busIf.wb_ready = (wbCyc == waitN + 1);
            end else begin
                busIf.wb_ready = 0;
            end
            if (busIf.snoop_done) begin
                doneCyc = cyc;
                gotHit  = busIf.snoop_hit;
            end
        end
        busIf.wb_ready = 0;
        cpu_we = 0;
        expDone = 2 + (expWb ? waitN + 1 : 0);
        check({name, "_latency"}, doneCyc, expDone);
        check({name, "_hit"}, gotHit, expHit);
        check({name, "_wbCycles"}, wbCyc, expWb ? waitN + 1 : 0);
        check({name, "_abortCycles"}, abCyc, expWb ? waitN + 2 : 0);
        check({name, "_wbPayload"}, dataOk, 1);
        checkStatus(name);
    endtask

    initial begin
        bit gotHit;
        int wbCyc;
        bit sawWb;
        int doneSeen;

        vecs[0]  = '{0, 3'd0, 5'h00, 3'b000, 32'h0,        2'b01, 8'h15, 0, 0, 0, 0};
        vecs[1]  = '{1, 3'd2, 5'h03, 3'b011, 32'h11111111, 2'b01, 8'h1A, 0, 1, 0, 0};
        vecs[2]  = '{0, 3'd0, 5'h00, 3'b000, 32'h0,        2'b10, 8'h1A, 0, 1, 0, 0};
        vecs[3]  = '{0, 3'd0, 5'h00, 3'b000, 32'h0,        2'b01, 8'h1A, 0, 0, 0, 0};
        vecs[4]  = '{1, 3'd1, 5'h0A, 3'b010, 32'h22222222, 2'b10, 8'h59, 0, 0, 0, 0};
        vecs[5]  = '{0, 3'd0, 5'h00, 3'b000, 32'h0,        2'b01, 8'h51, 0, 1, 0, 0};
        vecs[6]  = '{1, 3'd4, 5'h1F, 3'b001, 32'hDEADBEEF, 2'b10, 8'hFC, 4, 1, 5, 0};
        vecs[7]  = '{0, 3'd0, 5'h00, 3'b000, 32'h0,        2'b01, 8'hFC, 0, 0, 0, 0};
        vecs[8]  = '{1, 3'd5, 5'h07, 3'b001, 32'h12345678, 2'b01, 8'h3D, 0, 1, 1, 0};
        vecs[9]  = '{0, 3'd0, 5'h00, 3'b000, 32'h0,        2'b11, 8'h3D, 0, 1, 0, 0};
        vecs[10] = '{1, 3'd6, 5'h02, 3'b101, 32'h33333333, 2'b01, 8'h16, 0, 0, 0, 0};
        vecs[11] = '{1, 3'd6, 5'h02, 3'b111, 32'h44444444, 2'b11, 8'h16, 0, 0, 0, 0};
        vecs[12] = '{1, 3'd3, 5'h09, 3'b001, 32'h55555555, 2'b11, 8'h4B, 0, 1, 0, 1};

        busIf.snoop_valid = 0; busIf.snoop_op = 2'b00; busIf.snoop_addr = '0; busIf.wb_ready = 0;
        modelReset();

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_snoopReady", busIf.snoop_ready, 1);
        check("rst_cpuReady", cpu_ready, 1);
        check("rst_outputs", {busIf.abort_mem, busIf.wb_valid, busIf.snoop_done,
                              busIf.snoop_hit, proto_err}, 0);
        check("rst_wb", {busIf.wb_addr, busIf.wb_data}, 0);
        check("rst_counts", {hit_count, wb_count}, 0);
        reset = 1;

        // Directed vectors
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].we) cpuWrite(vecs[i].idx, vecs[i].tag, vecs[i].st, vecs[i].data);
            snoopTxn($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].waitN,
                     0, 3'd0, 5'd0, 3'd0, 32'd0, 0, gotHit, wbCyc);
            check($sformatf("vec%0d_tblHit", i), gotHit, vecs[i].expHit);
            check($sformatf("vec%0d_tblWb", i), wbCyc, vecs[i].expWb);
            check($sformatf("vec%0d_tblProto", i), proto_err, vecs[i].expProto);
        end

        // op 00 is never accepted
        @(negedge clock);
        busIf.snoop_valid = 1; busIf.snoop_op = 2'b00; busIf.snoop_addr = 8'h4B;
        doneSeen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check($sformatf("nop_ready%0d", k), busIf.snoop_ready, 1);
            if (busIf.snoop_done) doneSeen++;
        end
        busIf.snoop_valid = 0;
        check("nop_noDone", doneSeen, 0);

        // Install and accept in the same cycle: LOOKUP sees the new E line
        snoopTxn("sim", 2'b01, {5'h04, 3'd0}, 0, 1, 3'd0, 5'h04, 3'b011, 32'hA5A5A5A5,
                 0, gotHit, wbCyc);
        check("sim_hitNewLine", gotHit, 1);

        // Install attempted while busy is dropped: no M line, so no write-back
        snoopTxn("busy", 2'b01, {5'h04, 3'd0}, 0, 0, 3'd0, 5'd0, 3'd0, 32'd0, 1, gotHit, wbCyc);
        snoopTxn("busy2", 2'b10, {5'h04, 3'd0}, 0, 0, 3'd0, 5'd0, 3'd0, 32'd0, 0, gotHit, wbCyc);
        check("busy_noWb", wbCyc, 0);

        // Reset during write-back
        cpuWrite(3'd7, 5'h11, 3'b001, 32'hCAFEF00D);
        @(negedge clock);
        busIf.snoop_valid = 1; busIf.snoop_op = 2'b10; busIf.snoop_addr = {5'h11, 3'd7};
        @(posedge clock);
        #1 busIf.snoop_valid = 0;
        sawWb = 0;
        for (int k = 0; k < 10 && !sawWb; k++) begin
            @(negedge clock);
            if (busIf.wb_valid) sawWb = 1;
        end
        check("mrst_wbSeen", sawWb, 1);
        check("mrst_abortSeen", busIf.abort_mem, 1);
        #2 reset = 0;
        #1;
        check("mrst_wbDrop", busIf.wb_valid, 0);
        check("mrst_abortDrop", busIf.abort_mem, 0);
        check("mrst_ready", busIf.snoop_ready, 1);
        doneSeen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (busIf.snoop_done) doneSeen++;
        end
        check("mrst_noDone", doneSeen, 0);
        reset = 1;
        modelReset();
        snoopTxn("mrst_after", 2'b01, {5'h11, 3'd7}, 0, 0, 3'd0, 5'd0, 3'd0, 32'd0, 0,
                 gotHit, wbCyc);
        check("mrst_lineI", gotHit, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 150; n++) begin
            logic [2:0] rIdx;
            logic [4:0] rTag;
            rIdx = 3'($urandom_range(0, 7));
            rTag = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                cpuWrite(3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)),
                         3'($urandom_range(0, 7)), $urandom);
            snoopTxn($sformatf("rnd%0d", n), 2'($urandom_range(1, 3)), {rTag, rIdx},
                     int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                     3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)),
                     3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) == 0,
                     gotHit, wbCyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
